signal_gate_stretch: RTL and testbench

- Pulse shaper that sits directly downstream of the 512-deep programmable signal delay stage.
- Converts each rising edge of the delayed 1-bit trigger into a clean gate of programmable width, followed by a programmable hold-off (dead time).
- Keeps saturating counts of accepted and rejected triggers for the readout registers.
- Output drives front-panel/backplane trigger logic.

---
 rtl/signal_gate_stretch.sv | 144 ++++++++++++++
 tb/tb_signal_gate_stretch.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/signal_gate_stretch.sv
// signal_gate_stretch: turns each rising edge of the delayed trigger into a
// gate of programmable width, followed by a programmable hold-off. It also
// keeps saturating counts of accepted and rejected triggers.
// Build option: define SIGNAL_GATE_RETRIGGER_EN so that a rise during GATE
// restarts the gate instead of being rejected.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | waiting for a rise on din while enable is high
//   GATE    | dout high; cnt counts down the latched width
//   HOLDOFF | dout low, dead time; cnt counts down the latched hold-off
module signal_gate_stretch #(
    parameter int CNT_W  = 10,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              enable,
    input  logic [CNT_W-1:0]  width,
    input  logic [CNT_W-1:0]  holdoff,
    input  logic              cnt_clr,
    output logic              dout,
    output logic              busy,
    output logic [STAT_W-1:0] acc_cnt,
    output logic [STAT_W-1:0] rej_cnt
);

`ifdef SIGNAL_GATE_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GATE    = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   width_l;
    logic [CNT_W-1:0]   holdoff_l;
    logic               din_d;
    logic               rise;
    logic               acc_inc;
    logic               rej_inc;

    // Classify each rising edge of din as accepted, rejected or ignored.
    always_comb begin
        rise    = din & ~din_d;
        acc_inc = 1'b0;
        rej_inc = 1'b0;
        if (rise) begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        if (width != '0) acc_inc = 1'b1;
                        else             rej_inc = 1'b1;
                    end
                end
                GATE: begin
                    if (RETRIG) acc_inc = 1'b1;
                    else        rej_inc = 1'b1;
                end
                HOLDOFF: rej_inc = 1'b1;
                default: begin
                    acc_inc = 1'b0;
                    rej_inc = 1'b0;
                end
            endcase
        end
    end

    // Gate/hold-off state machine; dout and busy come straight from flops.
    // din_d resets high so a din held high through reset does not fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            width_l   <= '0;
            holdoff_l <= '0;
            dout      <= 1'b0;
            busy      <= 1'b0;
            din_d     <= 1'b1;
        end else begin
            din_d <= din;
            case (state)
                IDLE: begin
                    if (rise && enable && (width != '0)) begin
                        state     <= GATE;
                        width_l   <= width;
                        holdoff_l <= holdoff;
                        cnt       <= width - CNT_W'(1);
                        dout      <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                GATE: begin
                    if (RETRIG && rise) begin
                        cnt <= width_l - CNT_W'(1);
                    end else if (cnt == '0) begin
                        dout <= 1'b0;
                        if (holdoff_l != '0) begin
                            state <= HOLDOFF;
                            cnt   <= holdoff_l - CNT_W'(1);
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLDOFF: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating trigger statistics; a clear wins over a coincident increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            acc_cnt <= '0;
            rej_cnt <= '0;
        end else begin
            if (acc_inc && (acc_cnt != '1)) acc_cnt <= acc_cnt + STAT_W'(1);
            if (rej_inc && (rej_cnt != '1)) rej_cnt <= rej_cnt + STAT_W'(1);
        end
    end

endmodule

// File: tb/tb_signal_gate_stretch.sv
// Bench for signal_gate_stretch: expected gates are queued as triggers are
// driven and compared as each busy window closes; counters checked directly.
module tb_signal_gate_stretch;

    localparam int CNT_W  = 10;
    localparam int STAT_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              din;
    logic              enable;
    logic [CNT_W-1:0]  width;
    logic [CNT_W-1:0]  holdoff;
    logic              cnt_clr;
    logic              dout;
    logic              busy;
    logic [STAT_W-1:0] acc_cnt;
    logic [STAT_W-1:0] rej_cnt;

    signal_gate_stretch #(.CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .din     (din),
        .enable  (enable),
        .width   (width),
        .holdoff (holdoff),
        .cnt_clr (cnt_clr),
        .dout    (dout),
        .busy    (busy),
        .acc_cnt (acc_cnt),
        .rej_cnt (rej_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad   = 0;
    int exp_acc = 0;
    int exp_rej = 0;

    typedef struct {
        int start;
        int dlen;
        int blen;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: measure each busy window and the dout pulse inside it.
    int brun = 0, drun = 0, bstart = 0, dstart = 0;
    always @(negedge clk) begin
        if (busy) begin
            if (brun == 0) bstart = cyc;
            brun++;
            if (dout) begin
                if (drun == 0) dstart = cyc;
                drun++;
            end
        end else begin
            if (dout) chk("dout_without_busy", 1, 0);
            if (brun > 0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_gate", brun, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("gate_start", dstart, e.start);
                    chk("gate_len",   drun,   e.dlen);
                    chk("busy_start", bstart, e.start);
                    chk("busy_len",   brun,   e.blen);
                end
                brun = 0;
                drun = 0;
            end
        end
    end

    // Make din high so that it is sampled at rising edge e (one-cycle pulse).
    task automatic rise_at(input int e, input bit clr);
        while (cyc < e - 1) @(negedge clk);
        din     = 1'b1;
        cnt_clr = clr;
        @(negedge clk);
        din     = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic push(input int s, input int d, input int b);
        exp_t e;
        e.start = s;
        e.dlen  = d;
        e.blen  = b;
        sb.push_back(e);
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_counts(input string tag);
        chk({tag, "_acc"}, int'(acc_cnt), exp_acc);
        chk({tag, "_rej"}, int'(rej_cnt), exp_rej);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int s;

    initial begin
        rst     = 1'b1;
        din     = 1'b1;
        enable  = 1'b1;
        width   = 10'd5;
        holdoff = 10'd0;
        cnt_clr = 1'b0;
        settle(3);
        chk("rst_dout", int'(dout), 0);
        chk("rst_busy", int'(busy), 0);
        check_counts("rst");

        // din held high across reset release must not trigger.
        rst = 1'b0;
        settle(6);
        chk("hold_high_dout", int'(dout), 0);
        chk("hold_high_busy", int'(busy), 0);
        check_counts("hold_high");
        din = 1'b0;
        settle(2);

        // Single gate, width 5, no hold-off.
        s = cyc + 2;
        push(s, 5, 5);
        rise_at(s, 1'b0);
        width = 10'd9;
        settle(10);
        exp_acc = 1;
        check_counts("single");

        // Hold-off rejects a rise; a later rise is accepted.
        width   = 10'd4;
        holdoff = 10'd3;
        s = cyc + 2;
        push(s, 4, 7);
        push(s + 8, 4, 7);
        rise_at(s, 1'b0);
        rise_at(s + 5, 1'b0);
        rise_at(s + 8, 1'b0);
        settle(12);
        exp_acc += 2;
        exp_rej += 1;
        check_counts("holdoff");

        // Zero width rejects; disabled ignores.
        width   = 10'd0;
        holdoff = 10'd0;
        for (int i = 0; i < 3; i++) rise_at(cyc + 2, 1'b0);
        exp_rej += 3;
        check_counts("width0");
        enable = 1'b0;
        width  = 10'd5;
        for (int i = 0; i < 2; i++) rise_at(cyc + 2, 1'b0);
        settle(8);
        check_counts("disabled");
        enable = 1'b1;

        // Second rise three cycles into a width-6 gate.
        width = 10'd6;
        s = cyc + 2;
`ifdef SIGNAL_GATE_RETRIGGER_EN
        push(s, 9, 9);
        exp_acc += 2;
`else
        push(s, 6, 6);
        exp_acc += 1;
        exp_rej += 1;
`endif
        rise_at(s, 1'b0);
        rise_at(s + 3, 1'b0);
        settle(14);
        check_counts("retrig");

        // Rise on the final gate cycle, then rise one cycle after gate end.
        width = 10'd3;
        s = cyc + 2;
`ifdef SIGNAL_GATE_RETRIGGER_EN
        push(s, 6, 6);
        exp_acc += 2;
`else
        push(s, 3, 3);
        exp_acc += 1;
        exp_rej += 1;
`endif
        rise_at(s, 1'b0);
        rise_at(s + 3, 1'b0);
        settle(10);
        s = cyc + 2;
        push(s, 3, 3);
        push(s + 4, 3, 3);
        rise_at(s, 1'b0);
        rise_at(s + 4, 1'b0);
        settle(8);
        exp_acc += 2;
        check_counts("back2back");

        // Reset asserted on the third cycle of a width-10 gate.
        width   = 10'd10;
        holdoff = 10'd2;
        s = cyc + 2;
        push(s, 2, 2);
        rise_at(s, 1'b0);
        while (cyc < s + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_dout", int'(dout), 0);
        chk("midrst_busy", int'(busy), 0);
        exp_acc = 0;
        exp_rej = 0;
        check_counts("midrst");
        settle(14);
        chk("midrst_idle_busy", int'(busy), 0);

        // Saturation of rej_cnt and clear winning over a reject.
        width = 10'd0;
        force dut.rej_cnt = 16'hFFFD;
        @(negedge clk);
        release dut.rej_cnt;
        exp_rej = 65533;
        check_counts("preload");
        for (int i = 0; i < 4; i++) rise_at(cyc + 2, 1'b0);
        exp_rej = 65535;
        check_counts("saturate");
        rise_at(cyc + 2, 1'b1);
        exp_rej = 0;
        exp_acc = 0;
        check_counts("clr_vs_rej");

        settle(4);
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
